// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared LSU state encoding, access-size encodings and alignment check
package load_store_unit_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} lsu_state_t;
  localparam logic [1:0] BYTE = 2'b00;
  localparam logic [1:0] HALF_WORD = 2'b01;
  localparam logic [1:0] WORD = 2'b10;
  function automatic logic is_legal(input logic [1:0] size, input logic [1:0] off);
    return size == BYTE || (size == HALF_WORD && !off[0]) || (size == WORD && off == 2'b00);
  endfunction
endpackage

// File: rtl/load_store_unit_load_align.sv
// load_store_unit_load_align: shifts the read word by byte offset and sign/zero-extends to 32 bits
module load_store_unit_load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        zero_extnd,
  output logic [31:0] result
);
  logic [31:0] sh;
  assign sh = rdata >> {off, 3'b000};
  assign result = size == BYTE      ? {{24{!zero_extnd && sh[7]}}, sh[7:0]} :
                  size == HALF_WORD ? {{16{!zero_extnd && sh[15]}}, sh[15:0]} : sh;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory stage driving a req/gnt/rvalid data port, returning extended load data, with stall, fault and timeout
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        data_req_i,
  input  logic        data_wr_i,
  input  logic [1:0]  data_byte_i,
  input  logic        zero_extnd_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_wr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        lsu_stall_o,
  output logic [31:0] ld_data_o,
  output logic        ld_valid_o,
  output logic        lsu_fault_o
);
  lsu_state_t state;
  logic [31:0] cnt;
  logic [1:0] sz_q, off_q;
  logic ext_q, legal, tmo;
  logic [3:0] be;
  logic [31:0] wd, ld_res;
  assign legal = is_legal(data_byte_i, data_addr_i[1:0]);
  assign tmo = TIMEOUT_CYCLES != 0 && cnt == TIMEOUT_CYCLES - 1;
  assign lsu_stall_o = (state == IDLE && data_req_i && legal) || state == REQ || state == RESP;
  assign be = data_byte_i == BYTE      ? 4'b0001 << data_addr_i[1:0] :
              data_byte_i == HALF_WORD ? 4'b0011 << data_addr_i[1:0] : 4'b1111;
  assign wd = data_byte_i == BYTE      ? {4{data_wdata_i[7:0]}} :
              data_byte_i == HALF_WORD ? {2{data_wdata_i[15:0]}} : data_wdata_i;
  load_store_unit_load_align u_align (
    .rdata(mem_rdata_i),
    .off(off_q),
    .size(sz_q),
    .zero_extnd(ext_q),
    .result(ld_res)
  );
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state <= IDLE;
      cnt <= '0;
      mem_req_o <= 1'b0;
      mem_wr_o <= 1'b0;
      mem_be_o <= '0;
      mem_addr_o <= '0;
      mem_wdata_o <= '0;
      ld_data_o <= '0;
      ld_valid_o <= 1'b0;
      lsu_fault_o <= 1'b0;
      sz_q <= '0;
      off_q <= '0;
      ext_q <= 1'b0;
    end else begin
      cnt <= cnt + 1;
      ld_valid_o <= 1'b0;
      lsu_fault_o <= 1'b0;
      case (state)
        IDLE: if (data_req_i && legal) begin
          state <= REQ;
          cnt <= '0;
          mem_req_o <= 1'b1;
          mem_addr_o <= {data_addr_i[31:2], 2'b00};
          mem_wr_o <= data_wr_i;
          mem_be_o <= be;
          mem_wdata_o <= wd;
          sz_q <= data_byte_i;
          off_q <= data_addr_i[1:0];
          ext_q <= zero_extnd_i;
        end else if (data_req_i) begin
          state <= DONE;
          cnt <= '0;
          lsu_fault_o <= 1'b1;
        end
        REQ: if (mem_gnt_i) begin
          state <= mem_wr_o ? DONE : RESP;
          cnt <= '0;
          mem_req_o <= 1'b0;
        end else if (tmo) begin
          state <= DONE;
          cnt <= '0;
          mem_req_o <= 1'b0;
          lsu_fault_o <= 1'b1;
        end
        RESP: if (mem_rvalid_i) begin
          state <= DONE;
          cnt <= '0;
          ld_data_o <= ld_res;
          ld_valid_o <= 1'b1;
        end else if (tmo) begin
          state <= DONE;
          cnt <= '0;
          lsu_fault_o <= 1'b1;
        end
        default: begin
          state <= IDLE;
          cnt <= '0;
        end
      endcase
    end
  end
endmodule
